// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUOp/MDURead encodings and default latencies shared by mdu, controller and stall unit
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage bundle between the pipeline (master) and the MDU (slave)
//   A, B    : rs/rt operands          MDUOp   : operation code (mdu_op_e)
//   MDURead : 0 = LO, 1 = HI onto Out Out     : selected HI/LO
//   Busy    : mult/div in flight, feeds stall logic
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0] MDUOp;
  logic MDURead;
  logic [31:0] Out;
  logic Busy;
  modport master (output A, B, MDUOp, MDURead, input Out, Busy);
  modport slave (input A, B, MDUOp, MDURead, output Out, Busy);
endinterface

// File: rtl/mdu.sv
// mdu: multicycle multiply/divide unit with architectural HI/LO
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears HI/LO/pending/cnt
//   bus   : mdu_if.slave (A, B, MDUOp, MDURead in; Out, Busy out)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);
  localparam int MX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MX + 1) < 4 ? 4 : $clog2(MX + 1);
  logic [31:0] hi, lo, phi, plo, nhi, nlo, ua, ub, uq, ur;
  logic [63:0] prod;
  logic [CW-1:0] cnt;
  logic busy, is_mul, is_div, sgn, accept;
  assign busy = cnt != '0;
  assign is_mul = bus.MDUOp == OP_MULT || bus.MDUOp == OP_MULTU;
  assign is_div = bus.MDUOp == OP_DIV || bus.MDUOp == OP_DIVU;
  assign sgn = bus.MDUOp == OP_MULT || bus.MDUOp == OP_DIV;
  assign accept = !busy && (is_mul || is_div);
  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  // A zero divisor reloads the current HI/LO so the commit leaves them unchanged.
  always_comb begin
    ua = sgn && bus.A[31] ? -bus.A : bus.A;
    ub = sgn && bus.B[31] ? -bus.B : bus.B;
    uq = ub == '0 ? '0 : ua / ub;
    ur = ub == '0 ? '0 : ua % ub;
    prod = sgn ? {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B} : {32'b0, bus.A} * {32'b0, bus.B};
    nhi = is_mul ? prod[63:32] : ub == '0 ? hi : sgn && bus.A[31] ? -ur : ur;
    nlo = is_mul ? prod[31:0] : ub == '0 ? lo : sgn && (bus.A[31] ^ bus.B[31]) ? -uq : uq;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phi <= '0;
      plo <= '0;
    end else if (accept) begin
      phi <= nhi;
      plo <= nlo;
    end
  // Any op seen while busy (including on the committing edge) is dropped.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi <= phi;
        lo <= plo;
      end
    end else begin
      if (is_mul) cnt <= CW'(MULT_CYCLES);
      if (is_div) cnt <= CW'(DIV_CYCLES);
      if (bus.MDUOp == OP_MTHI) hi <= bus.A;
      if (bus.MDUOp == OP_MTLO) lo <= bus.A;
    end
  assign bus.Out = bus.MDURead == RD_HI ? hi : lo;
  assign bus.Busy = busy;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu with directed, hand-computed vectors
module tb_mdu;
  import mdu_pkg::*;
  typedef struct {
    string name;
    logic [31:0] val;
    logic busy;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk = 1'b0;
  int checks = 0;
  int errors = 0;
  int run = 0;
  int bq[$];
  exp_t oq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  mdu_if bus();
  mdu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    if (bus.Busy) run++;
    else if (run > 0) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL busy_len unexpected: got %0d cycles, expected none", run);
      end else begin
        int e;
        e = bq.pop_front();
        if (e != run) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles, expected %0d", run, e);
        end
      end
      run = 0;
    end
    if (chk) begin
      exp_t x;
      checks++;
      if (oq.size() == 0) begin
        errors++;
        $display("FAIL out_queue: empty at sample");
      end else begin
        x = oq.pop_front();
        if (bus.Out !== x.val || bus.Busy !== x.busy) begin
          errors++;
          $display("FAIL %s: Out=%h Busy=%b expected Out=%h Busy=%b", x.name, bus.Out, bus.Busy, x.val, x.busy);
        end
      end
    end
  end
  task automatic expect_out(input string name, input logic sel, input logic [31:0] val, input logic bsy);
    exp_t x;
    x.name = name;
    x.val = val;
    x.busy = bsy;
    oq.push_back(x);
    bus.MDURead = sel;
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.MDUOp = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1 bus.MDUOp = OP_NONE;
  endtask
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] nhi, input logic [31:0] nlo);
    bq.push_back(n);
    issue(op, a, b);
    for (int i = 0; i < n; i++) expect_out({name, "_old"}, i[0], i[0] ? m_hi : m_lo, 1'b1);
    m_hi = nhi;
    m_lo = nlo;
    expect_out({name, "_lo"}, RD_LO, m_lo, 1'b0);
    expect_out({name, "_hi"}, RD_HI, m_hi, 1'b0);
  endtask
  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.MDUOp = OP_NONE;
    bus.MDURead = RD_LO;
    #2;
    expect_out("reset_lo", RD_LO, 32'h0, 1'b0);
    expect_out("reset_hi", RD_HI, 32'h0, 1'b0);
    reset = 1'b1;
    bus.MDUOp = OP_MTHI;
    bus.A = 32'h12345678;
    @(posedge clk);
    #1 bus.MDUOp = OP_NONE;
    m_hi = 32'h12345678;
    expect_out("mthi_first_edge", RD_HI, m_hi, 1'b0);
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
    m_lo = 32'hCAFEF00D;
    expect_out("mtlo", RD_LO, m_lo, 1'b0);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", OP_DIV, 32'h7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 10, 32'd2, 32'd14);
    bq.push_back(10);
    issue(OP_DIV, 32'd23, 32'd5);
    issue(OP_MTLO, 32'h0000DEAD, 32'h0);
    expect_out("mtlo_while_busy", RD_LO, m_lo, 1'b1);
    repeat (6) @(posedge clk);
    issue(OP_MTHI, 32'h0000BEEF, 32'h0);
    m_hi = 32'd3;
    m_lo = 32'd4;
    expect_out("div_23_5_lo", RD_LO, m_lo, 1'b0);
    expect_out("op_on_commit_edge_hi", RD_HI, m_hi, 1'b0);
    bq.push_back(5);
    bq.push_back(5);
    @(posedge clk);
    #1;
    bus.MDUOp = OP_MULT;
    bus.A = 32'd3;
    bus.B = 32'd4;
    @(posedge clk);
    #1;
    bus.A = 32'hFFFFFFFB;
    bus.B = 32'd6;
    for (int i = 0; i < 5; i++) expect_out("b2b_first_old", i[0], i[0] ? m_hi : m_lo, 1'b1);
    m_hi = 32'h0;
    m_lo = 32'd12;
    expect_out("b2b_first_lo", RD_LO, m_lo, 1'b0);
    @(posedge clk);
    #1 bus.MDUOp = OP_NONE;
    for (int i = 0; i < 5; i++) expect_out("b2b_second_old", i[0], i[0] ? m_hi : m_lo, 1'b1);
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFFFFE2;
    expect_out("b2b_second_lo", RD_LO, m_lo, 1'b0);
    expect_out("b2b_second_hi", RD_HI, m_hi, 1'b0);
    bq.push_back(4);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    expect_out("abort_lo", RD_LO, 32'h0, 1'b0);
    expect_out("abort_hi", RD_HI, 32'h0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) expect_out("no_stale_commit", i[0], 32'h0, 1'b0);
    issue(OP_MTLO, 32'h55, 32'h0);
    expect_out("post_reset_mtlo", RD_LO, 32'h55, 1'b0);
    expect_out("post_reset_hi", RD_HI, 32'h0, 1'b0);
    checks++;
    if (bq.size() != 0 || oq.size() != 0) begin
      errors++;
      $display("FAIL leftover: busy_q=%0d out_q=%0d expected 0 0", bq.size(), oq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
